boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64: instruction-memory words available; legal range 2..4096.
REQ-002 The module SHALL have parameter TIMEOUT, default 16'd4000: RUN cycle limit before a timeout error.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: single-cycle load request.
REQ-006 The module SHALL have port in_valid, input, 1 bit: upstream machine word valid.
REQ-007 The module SHALL have port in_data, input, 9 bits: machine code word.
REQ-008 The module SHALL have port in_last, input, 1 bit: final word of the program, qualified by in_valid.
REQ-009 The module SHALL have port in_ready, output, 1 bit: loader accepts a word this cycle.
REQ-010 The module SHALL have port imem_wen, output, 1 bit: instruction-ROM write strobe.
REQ-011 The module SHALL have port imem_addr, output, 12 bits: instruction-ROM write address, matching PC width.
REQ-012 The module SHALL have port imem_wdat, output, 9 bits: instruction-ROM write data.
REQ-013 The module SHALL have port core_reset, output, 1 bit: active-high reset to the processor core.
REQ-014 The module SHALL have port core_done, input, 1 bit: processor done flag.
REQ-015 The module SHALL have port sys_done, output, 1 bit: program completed.
REQ-016 The module SHALL have port err, output, 1 bit: error latched.
REQ-017 The module SHALL have port err_code, output, 2 bits: 01 = overflow, 10 = timeout, 00 = none.
REQ-018 The module SHALL have port word_count, output, 13 bits: words accepted in the current load.
REQ-019 The module SHALL have port cycles, output, 16 bits: core run cycles.

Function
REQ-020 The module SHALL implement states IDLE, LOAD, RELEASE, RUN, HALT and ERR.
REQ-021 From IDLE, HALT or ERR, start=1 SHALL go to LOAD next cycle and clear word_count, cycles, sys_done, err and err_code; start SHALL be ignored in LOAD, RELEASE and RUN.
REQ-022 in_ready SHALL be 1 exactly when state is LOAD, combinational from state; in_valid when in_ready=0 SHALL be ignored with no write.
REQ-023 An accepted word (in_valid & in_ready) SHALL produce, on the next cycle, imem_wen=1, imem_addr=word_count before increment, imem_wdat=in_data registered; imem_wen SHALL be 0 otherwise; word_count SHALL increment by 1.
REQ-024 Back-to-back accepts SHALL sustain one word per cycle with consecutive addresses.
REQ-025 Accepted word with in_last=1 SHALL go to RELEASE; this includes the word at address DEPTH-1.
REQ-026 Accepted word at address DEPTH-1 with in_last=0 SHALL still be written, then go to ERR with err_code=01.
REQ-027 RELEASE SHALL last exactly one cycle, during which the final write lands, then go to RUN.
REQ-028 core_reset SHALL be 0 only in RUN and 1 in all other states, including HALT, which freezes the core.
REQ-029 In RUN, cycles SHALL increment by 1 per cycle and saturate at 16'hFFFF.
REQ-030 In RUN, core_done=1 SHALL go to HALT and set sys_done=1 (registered); sys_done SHALL hold until start or reset.
REQ-031 In RUN, cycles reaching TIMEOUT with core_done=0 SHALL go to ERR with err_code=10.
REQ-032 If core_done and the timeout occur in the same cycle, done SHALL win.
REQ-033 core_done outside RUN SHALL be ignored.
REQ-034 err SHALL be 1 exactly when err_code is nonzero.

Reset
REQ-035 reset=0 SHALL immediately, asynchronously force state IDLE, core_reset=1, in_ready=0, imem_wen=0, imem_addr=0, imem_wdat=0, word_count=0, cycles=0, sys_done=0, err=0, err_code=0.
REQ-036 Reset asserted mid-LOAD or mid-RUN SHALL abort the operation with no further writes; release SHALL resume in IDLE on the first clk edge after deassertion.

Verification
REQ-037 Reset, then start, then 3 words 9'h101, 9'h0A5, 9'h1FF with the last one flagged -> writes to addresses 0, 1, 2 on consecutive cycles; word_count=3; RELEASE for 1 cycle; core_reset falls.
REQ-038 in_valid gapped (1,0,1) during LOAD -> only 2 writes, addresses 0 and 1, with no strobe in the gap cycle.
REQ-039 DEPTH=4, 4 words with no in_last -> 4 writes to addresses 0-3, err=1, err_code=01, core_reset stays 1.
REQ-040 Load completes, core_done raised after 10 RUN cycles -> cycles=10, sys_done=1, core_reset=1 in HALT; start then clears all and re-enters LOAD.
REQ-041 TIMEOUT=5 with core_done never asserted -> ERR, err_code=10, cycles=5; a second case with core_done on the 5th cycle -> HALT, err=0.
REQ-042 reset=0 pulsed between clock edges during LOAD -> outputs reach their reset values before the next edge, and no imem_wen follows.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: streams a machine-code image into instruction memory, then
// releases the core and supervises its run (done / timeout / overflow).
`default_nettype none

module boot_loader #(
  parameter int          DEPTH   = 64,
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [8:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        imem_wen,
  output logic [11:0] imem_addr,
  output logic [8:0]  imem_wdat,
  output logic        core_reset,
  input  logic        core_done,
  output logic        sys_done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [12:0] word_count,
  output logic [15:0] cycles
);

  localparam logic [2:0]  S_IDLE    = 3'd0;
  localparam logic [2:0]  S_LOAD    = 3'd1;
  localparam logic [2:0]  S_RELEASE = 3'd2;
  localparam logic [2:0]  S_RUN     = 3'd3;
  localparam logic [2:0]  S_HALT    = 3'd4;
  localparam logic [2:0]  S_ERR     = 3'd5;
  localparam logic [12:0] LAST_ADDR = 13'(DEPTH - 1);
  localparam logic [1:0]  ERR_OVF   = 2'b01;
  localparam logic [1:0]  ERR_TMO   = 2'b10;

  logic [2:0]  state_q, state_d;
  logic        wen_q, wen_d;
  logic [11:0] addr_q, addr_d;
  logic [8:0]  wdat_q, wdat_d;
  logic [12:0] wc_q, wc_d;
  logic [15:0] cyc_q, cyc_d;
  logic        sdone_q, sdone_d;
  logic [1:0]  code_q, code_d;
  logic [16:0] cyc_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      wc_q    <= '0;
      cyc_q   <= '0;
      sdone_q <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      wc_q    <= wc_d;
      cyc_q   <= cyc_d;
      sdone_q <= sdone_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    wc_d    = wc_q;
    cyc_d   = cyc_q;
    sdone_d = sdone_q;
    code_d  = code_q;
    cyc_inc = {1'b0, cyc_q} + 17'd1;
    case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          wc_d    = '0;
          cyc_d   = '0;
          sdone_d = 1'b0;
          code_d  = '0;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready) begin
          wen_d  = 1'b1;
          addr_d = wc_q[11:0];
          wdat_d = in_data;
          wc_d   = wc_q + 13'd1;
          // A flagged last word always completes the load, even at the top address.
          if (in_last) begin
            state_d = S_RELEASE;
          end else if (wc_q == LAST_ADDR) begin
            state_d = S_ERR;
            code_d  = ERR_OVF;
          end
        end
      end
      S_RELEASE: state_d = S_RUN;
      S_RUN: begin
        cyc_d = cyc_inc[16] ? 16'hFFFF : cyc_inc[15:0];
        if (core_done) begin
          state_d = S_HALT;
          sdone_d = 1'b1;
        end else if (cyc_inc >= {1'b0, TIMEOUT}) begin
          state_d = S_ERR;
          code_d  = ERR_TMO;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == S_LOAD);
    core_reset = (state_q != S_RUN);
    err        = |code_q;
  end

  assign imem_wen   = wen_q;
  assign imem_addr  = addr_q;
  assign imem_wdat  = wdat_q;
  assign word_count = wc_q;
  assign cycles     = cyc_q;
  assign sys_done   = sdone_q;
  assign err_code   = code_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// tb_boot_loader: two boot_loader instances (default, and DEPTH=4/TIMEOUT=5)
// driven from a shared stimulus and checked against a queue-based model.
`default_nettype none

module tb_boot_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic core_done = 1'b0;
  logic [8:0] in_data = '0;

  logic a_ready, a_wen, a_creset, a_sdone, a_err;
  logic [11:0] a_addr;
  logic [8:0]  a_wdat;
  logic [1:0]  a_code;
  logic [12:0] a_wc;
  logic [15:0] a_cyc;
  logic b_ready, b_wen, b_creset, b_sdone, b_err;
  logic [11:0] b_addr;
  logic [8:0]  b_wdat;
  logic [1:0]  b_code;
  logic [12:0] b_wc;
  logic [15:0] b_cyc;

  logic o_ready, o_wen, o_creset, o_sdone, o_err;
  logic [11:0] o_addr;
  logic [8:0]  o_wdat;
  logic [1:0]  o_code;
  logic [12:0] o_wc;
  logic [15:0] o_cyc;

  int total = 0;
  int bad = 0;
  bit cur = 1'b0;
  logic [20:0] expq[$];
  logic [8:0]  dq[$];
  bit          vq[$];

  always #5 clk = ~clk;

  boot_loader #(.DEPTH(64), .TIMEOUT(16'd4000)) u_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(a_ready), .imem_wen(a_wen), .imem_addr(a_addr),
    .imem_wdat(a_wdat), .core_reset(a_creset), .core_done(core_done), .sys_done(a_sdone),
    .err(a_err), .err_code(a_code), .word_count(a_wc), .cycles(a_cyc)
  );

  boot_loader #(.DEPTH(4), .TIMEOUT(16'd5)) u_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(b_ready), .imem_wen(b_wen), .imem_addr(b_addr),
    .imem_wdat(b_wdat), .core_reset(b_creset), .core_done(core_done), .sys_done(b_sdone),
    .err(b_err), .err_code(b_code), .word_count(b_wc), .cycles(b_cyc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    if (cur) begin
      o_ready = b_ready; o_wen = b_wen; o_addr = b_addr; o_wdat = b_wdat;
      o_creset = b_creset; o_sdone = b_sdone; o_err = b_err; o_code = b_code;
      o_wc = b_wc; o_cyc = b_cyc;
    end else begin
      o_ready = a_ready; o_wen = a_wen; o_addr = a_addr; o_wdat = a_wdat;
      o_creset = a_creset; o_sdone = a_sdone; o_err = a_err; o_code = a_code;
      o_wc = a_wc; o_cyc = a_cyc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    snap();
  endtask

  task automatic check_write();
    logic [20:0] e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("wen", o_wen, 1);
      chk("addr", o_addr, e[20:9]);
      chk("wdat", o_wdat, e[8:0]);
    end else begin
      chk("no_wen", o_wen, 0);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, o_ready, 0);
    chk({tag, "_creset"}, o_creset, 1);
    chk({tag, "_wen"}, o_wen, 0);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_wdat"}, o_wdat, 0);
    chk({tag, "_wc"}, o_wc, 0);
    chk({tag, "_cyc"}, o_cyc, 0);
    chk({tag, "_sdone"}, o_sdone, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_code"}, o_code, 0);
  endtask

  task automatic do_reset(input bit sel);
    cur = sel;
    in_valid = 0; in_last = 0; start = 0; core_done = 0;
    reset = 0;
    tick();
    tick();
    reset = 1;
    tick();
    expq.delete();
  endtask

  // Load n words; the model expects word i at address i one cycle after acceptance.
  task automatic do_load(input int n, input bit use_last, input bit gaps);
    int i = 0;
    int idle = 0;
    int guard = 0;
    bit v;
    start = 1;
    tick();
    start = 0;
    check_write();
    chk("load_ready", o_ready, 1);
    chk("load_wc0", o_wc, 0);
    chk("load_cyc0", o_cyc, 0);
    chk("load_sdone0", o_sdone, 0);
    chk("load_err0", o_err, 0);
    chk("load_code0", o_code, 0);
    while (i < n && guard < 200) begin
      if (vq.size() != 0) v = vq.pop_front();
      else v = gaps ? (idle >= 2 || $urandom_range(0, 1) == 1) : 1'b1;
      in_valid = v;
      in_data = (v && dq.size() != 0) ? dq.pop_front() : 9'($urandom);
      in_last = use_last && v && (i == n - 1);
      if (v) begin
        expq.push_back({12'(i), in_data});
        i++;
        idle = 0;
      end else begin
        idle++;
      end
      tick();
      check_write();
      guard++;
    end
    in_valid = 0;
    in_last = 0;
    if (guard >= 200) chk("load_guard", 1, 0);
    chk("load_wc", o_wc, n);
  endtask

  task automatic after_last();
    chk("rel_ready", o_ready, 0);
    chk("rel_creset", o_creset, 1);
    chk("rel_err", o_err, 0);
    tick();
    check_write();
    chk("run_creset", o_creset, 0);
    chk("run_cyc0", o_cyc, 0);
  endtask

  task automatic do_run(input int done_at, input int max_k, input int start_at);
    for (int k = 1; k <= max_k; k++) begin
      core_done = (k == done_at);
      start = (k == start_at);
      tick();
      core_done = 0;
      start = 0;
      check_write();
      chk("run_cycles", o_cyc, k);
      if (k == done_at) break;
    end
  endtask

  task automatic end_check(input bit halt, input int cyc);
    chk("end_sdone", o_sdone, halt);
    chk("end_err", o_err, !halt);
    chk("end_code", o_code, halt ? 0 : 2);
    chk("end_cyc", o_cyc, cyc);
    chk("end_creset", o_creset, 1);
    chk("end_ready", o_ready, 0);
  endtask

  // Outcome of a run from the rules: done wins up to and including the timeout cycle.
  task automatic rand_run(input int tmo, input int max_done);
    int d;
    bit halt;
    d = $urandom_range(1, max_done);
    halt = (d <= tmo);
    do_run(d, halt ? d : tmo, 0);
    end_check(halt, halt ? d : tmo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    cur = 0; snap(); check_idle("por_a");
    cur = 1; snap(); check_idle("por_b");
    cur = 0;
    tick();
    reset = 1;
    tick();
    check_idle("idle_a");
    in_valid = 1;
    in_data = 9'h1AB;
    tick();
    check_write();
    chk("idle_ignore_wc", o_wc, 0);
    in_valid = 0;

    // Directed three-word image, then a 10-cycle run with start ignored mid-run.
    dq = '{9'h101, 9'h0A5, 9'h1FF};
    do_load(3, 1, 0);
    after_last();
    do_run(10, 10, 3);
    end_check(1, 10);
    core_done = 1;
    tick();
    core_done = 0;
    chk("halt_sdone_hold", o_sdone, 1);
    chk("halt_cyc_hold", o_cyc, 10);
    chk("halt_creset", o_creset, 1);
    do_load($urandom_range(1, 12), 1, 1);
    after_last();
    rand_run(4000, 30);

    // Gapped valid 1,0,1.
    do_reset(0);
    vq = '{1'b1, 1'b0, 1'b1};
    do_load(2, 1, 0);
    after_last();

    for (int r = 0; r < 3; r++) begin
      do_reset(0);
      do_load($urandom_range(1, 20), 1, 1);
      after_last();
      rand_run(4000, 25);
    end

    // Overflow at DEPTH=4.
    do_reset(1);
    do_load(4, 0, 1);
    chk("ovf_err", o_err, 1);
    chk("ovf_code", o_code, 1);
    chk("ovf_ready", o_ready, 0);
    chk("ovf_creset", o_creset, 1);
    in_valid = 1;
    tick();
    in_valid = 0;
    check_write();
    chk("ovf_creset2", o_creset, 1);
    chk("ovf_wc_hold", o_wc, 4);

    // Last word exactly at DEPTH-1, then timeout, then done on the timeout cycle.
    do_reset(1);
    do_load(4, 1, 0);
    chk("edge_code", o_code, 0);
    after_last();
    do_run(0, 5, 0);
    end_check(0, 5);
    do_load(2, 1, 1);
    after_last();
    do_run(5, 5, 0);
    end_check(1, 5);
    for (int r = 0; r < 3; r++) begin
      do_load($urandom_range(1, 4), 1, 1);
      after_last();
      rand_run(5, 8);
    end

    // Asynchronous reset between edges mid-load.
    do_reset(0);
    start = 1;
    tick();
    start = 0;
    in_valid = 1;
    in_data = 9'h0AA;
    expq.push_back({12'd0, 9'h0AA});
    tick();
    check_write();
    in_data = 9'h055;
    #1;
    reset = 0;
    #1;
    snap();
    check_idle("async");
    #1;
    reset = 1;
    tick();
    check_write();
    chk("async_ready", o_ready, 0);
    tick();
    check_write();
    chk("async_wc", o_wc, 0);
    in_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
